w5300_socket_n_conf: RTL
========================

Name: w5300_socket_n_conf

Overview:
- Generalised W5300 socket bring-up sequencer for socket N. Selectable mode: TCP server, TCP client or UDP.
- Drives the shared host-bus request (addr/wr_data), one register access per op_state handshake, after common-register configuration completes.
- Adds TCP-client connect, UDP open, status checking on completed reads, bounded close-and-retry with an error outcome, and restart on enable drop.

Parameters:
N, 0, socket index 0..7; register addresses via get_socket_n_reg(baseAddr, N)
MODE, 0, 0 = TCP server, 1 = TCP client, 2 = UDP; any other value behaves as 0
PORT, 7000, 16-bit local source port (Sn_PORTR)
DEST_IP, {8'd192,8'd168,8'd1,8'd100}, 32-bit peer IP (TCP client only)
DEST_PORT, 7000, 16-bit peer port (TCP client only)
KEEPALIVE, 8'd1, Sn_KPALVTR value in 5 s units (TCP modes)
STATUS_TIMEOUT, 16'd50, clk cycles allowed in WaitInit and in server WaitStatus
CONNECT_TIMEOUT, 32'd50_000_000, clk cycles allowed in client WaitStatus
MAX_RETRY, 4'd3, failed attempts before error; range 1..15

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  level; start request, held high for the whole run
op_state  input  1  one-cycle pulse: current bus access completed
rd_data  input  16  read data, valid in the op_state cycle of a read
addr  output  11  [10] = WR/RD flag from the W5300 package, [9:0] = register address
wr_data  output  16  write data, 0 for reads
done  output  1  socket reached target state; held until enable falls
error  output  1  MAX_RETRY attempts failed; held until enable falls

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state Idle; done=0, error=0; op_cnt, retry_cnt, tick_cnt = 0; addr={RD,10'h3fe}, wr_data=0.
- Every request is combinational from state and op_cnt. A step advances only in a cycle with op_state=1; op_state in Idle, Done or Fail is ignored.
- Idle: idle request. enable=1 -> WriteParams, with op_cnt=0 and retry_cnt=0.
- WriteParams: ordered writes, one per op_state; the last one is Sn_CR=OPEN (0x01).
  - Server: Sn_MR=0x0001 (P_TCP); PORTR=PORT; IMR=SENDOK|TIMEOUT|RECV|DISCON|CON; KPALVTR_PROTOR={KEEPALIVE,8'd0}; CR=OPEN. 5 ops.
  - Client: same as server, plus DIPR0=DEST_IP[31:16], DIPR2=DEST_IP[15:0], DPORTR=DEST_PORT before CR=OPEN. 8 ops.
  - UDP: Sn_MR=0x0002 (P_UDP); PORTR; IMR=SENDOK|TIMEOUT|RECV; CR=OPEN. 4 ops.
  - On the op_state of the last write: op_cnt=0, tick_cnt=0 -> WaitInit.
- WaitInit: reads Sn_SSR repeatedly. Status is judged only on an op_state cycle, using rd_data[7:0].
  - Expected value: 0x13 (SOCK_INIT) in TCP modes, 0x22 (SOCK_UDP) in UDP mode.
  - Match: UDP -> Done; TCP -> Command.
  - tick_cnt counts every cycle in the state. tick_cnt >= STATUS_TIMEOUT -> Close; timeout wins over a same-cycle match.
- Command: single write, CR=LISTEN (0x02) for server or CR=CONNECT (0x04) for client. op_state -> WaitStatus, tick_cnt=0.
- WaitStatus: reads Sn_SSR.
  - Server: 0x14 (LISTEN) -> Done; timeout STATUS_TIMEOUT.
  - Client: 0x17 (ESTABLISHED) -> Done; 0x00 (CLOSED) -> Close immediately; timeout CONNECT_TIMEOUT.
- Close: write CR=CLOSE (0x10). On op_state retry_cnt+1; if the new value == MAX_RETRY -> Fail, else -> WriteParams with op_cnt=0.
- Done: done=1 registered, asserted the cycle after entry. Fail: error=1 likewise. done and error are never both high.
- enable=0 in any non-Idle state -> Idle next cycle; done, error and all counters clear.
  - Mid-sequence abort issues no CLOSE; the host must re-enable to restart from op 0.
- tick_cnt is 32 bits, saturating, cleared on every state change.
- retry_cnt is 4 bits and clears only in Idle.

Test Plan:
- MODE=0, N=0: ack every request after 2 cycles, SSR returns 0x13 then 0x14 -> writes 0x0001, 0x1B58, IMR, 0x0100, 0x0001, then CR=0x0002; done=1, error=0.
- MODE=1: SSR gives 0x13, then 0x15 ×3, then 0x17 -> DIPR0=0xC0A8, DIPR2=0x0164, DPORTR=0x1B58 written before OPEN; CONNECT 0x0004 issued; done=1.
- MODE=2: SSR=0x22 -> 4 writes (Sn_MR=0x0002), no LISTEN/CONNECT write; done asserts one cycle after the matching read ack.
- MODE=0, MAX_RETRY=3, SSR stuck 0x00 -> three cycles of 50-cycle timeout then CR=0x0010; OPEN re-issued after closes 1 and 2; after close 3, error=1, done=0, no further requests.
- MODE=1, SSR returns 0x00 after CONNECT -> Close entered on that ack, before CONNECT_TIMEOUT expires; retry_cnt=1.
- enable dropped during WriteParams op 2, then rst_n pulsed mid-WaitStatus -> each returns to Idle, addr={RD,3FE}, done=error=0; re-enable restarts at Sn_MR write.

Source files
------------

// File: rtl/w5300_socket_n_conf_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | w5300_socket_n_conf_if : host-bus request/response bundle  | rev 1.0     |
// +--------------------------------------------------------------------------+
interface w5300_socket_n_conf_if;
  logic        enable;
  logic        op_state;
  logic [15:0] rd_data;
  logic [10:0] addr;
  logic [15:0] wr_data;
  logic        done;
  logic        error;

  modport master (
    input  enable, op_state, rd_data,
    output addr, wr_data, done, error
  );

  modport slave (
    output enable, op_state, rd_data,
    input  addr, wr_data, done, error
  );
endinterface
`default_nettype wire

// File: rtl/w5300_socket_n_conf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | w5300_socket_n_conf : W5300 socket N bring-up sequencer    | rev 1.0     |
// +--------------------------------------------------------------------------+
module w5300_socket_n_conf #(
  parameter int unsigned N               = 0,
  parameter int unsigned MODE            = 0,
  parameter logic [15:0] PORT            = 16'd7000,
  parameter logic [31:0] DEST_IP         = {8'd192, 8'd168, 8'd1, 8'd100},
  parameter logic [15:0] DEST_PORT       = 16'd7000,
  parameter logic [7:0]  KEEPALIVE       = 8'd1,
  parameter logic [15:0] STATUS_TIMEOUT  = 16'd50,
  parameter logic [31:0] CONNECT_TIMEOUT = 32'd50_000_000,
  parameter logic [3:0]  MAX_RETRY       = 4'd3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  w5300_socket_n_conf_if.master         bus
);

  function automatic logic [9:0] get_socket_n_reg(input logic [9:0] base_addr,
                                                  input int unsigned sock);
    return base_addr + 10'(sock * 32'd64);
  endfunction

  localparam logic       WR       = 1'b1;
  localparam logic       RD       = 1'b0;
  localparam logic [9:0] IDLE_REG = 10'h3fe;

  localparam logic [9:0] SN_MR     = get_socket_n_reg(10'h200, N);
  localparam logic [9:0] SN_CR     = get_socket_n_reg(10'h202, N);
  localparam logic [9:0] SN_IMR    = get_socket_n_reg(10'h204, N);
  localparam logic [9:0] SN_SSR    = get_socket_n_reg(10'h208, N);
  localparam logic [9:0] SN_PORTR  = get_socket_n_reg(10'h20a, N);
  localparam logic [9:0] SN_DPORTR = get_socket_n_reg(10'h212, N);
  localparam logic [9:0] SN_DIPR0  = get_socket_n_reg(10'h214, N);
  localparam logic [9:0] SN_DIPR2  = get_socket_n_reg(10'h216, N);
  localparam logic [9:0] SN_KPALV  = get_socket_n_reg(10'h21a, N);

  // Out-of-range MODE values fall back to TCP server.
  localparam bit          IS_CLIENT  = (MODE == 1);
  localparam bit          IS_UDP     = (MODE == 2);
  localparam logic [3:0]  LAST_OP    = IS_UDP ? 4'd3 : (IS_CLIENT ? 4'd7 : 4'd4);
  localparam logic [15:0] MR_VAL     = IS_UDP ? 16'h0002 : 16'h0001;
  localparam logic [15:0] IMR_VAL    = IS_UDP ? 16'h001c : 16'h001f;
  localparam logic [15:0] CMD_VAL    = IS_CLIENT ? 16'h0004 : 16'h0002;
  localparam logic [7:0]  INIT_SSR   = IS_UDP ? 8'h22 : 8'h13;
  localparam logic [7:0]  TARGET_SSR = IS_CLIENT ? 8'h17 : 8'h14;
  localparam logic [31:0] INIT_LIMIT = {16'd0, STATUS_TIMEOUT};
  localparam logic [31:0] STAT_LIMIT = IS_CLIENT ? CONNECT_TIMEOUT : {16'd0, STATUS_TIMEOUT};

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WRITE       = 3'd1,
    S_WAIT_INIT   = 3'd2,
    S_COMMAND     = 3'd3,
    S_WAIT_STATUS = 3'd4,
    S_CLOSE       = 3'd5,
    S_DONE        = 3'd6,
    S_FAIL        = 3'd7
  } state_t;

  state_t      state;
  logic [3:0]  op_cnt;
  logic [3:0]  retry_cnt;
  logic [31:0] tick_cnt;
  logic        done_reg;
  logic        error_reg;

  logic [31:0] tick_inc;
  logic [3:0]  retry_inc;
  logic [7:0]  ssr;
  logic        req_wr;
  logic [9:0]  req_reg;
  logic [15:0] req_data;

  assign tick_inc  = (tick_cnt == 32'hffff_ffff) ? tick_cnt : tick_cnt + 32'd1;
  assign retry_inc = retry_cnt + 4'd1;
  assign ssr       = bus.rd_data[7:0];

  always_comb begin
    req_wr   = RD;
    req_reg  = IDLE_REG;
    req_data = 16'h0000;
    case (state)
      S_WRITE: begin
        req_wr = WR;
        if (op_cnt == LAST_OP) begin
          req_reg  = SN_CR;
          req_data = 16'h0001;
        end else begin
          case (op_cnt)
            4'd0:    begin req_reg = SN_MR;     req_data = MR_VAL;              end
            4'd1:    begin req_reg = SN_PORTR;  req_data = PORT;                end
            4'd2:    begin req_reg = SN_IMR;    req_data = IMR_VAL;             end
            4'd3:    begin req_reg = SN_KPALV;  req_data = {KEEPALIVE, 8'd0};   end
            4'd4:    begin req_reg = SN_DIPR0;  req_data = DEST_IP[31:16];      end
            4'd5:    begin req_reg = SN_DIPR2;  req_data = DEST_IP[15:0];       end
            4'd6:    begin req_reg = SN_DPORTR; req_data = DEST_PORT;           end
            default: begin req_reg = SN_CR;     req_data = 16'h0001;            end
          endcase
        end
      end
      S_WAIT_INIT, S_WAIT_STATUS: req_reg = SN_SSR;
      S_COMMAND: begin
        req_wr   = WR;
        req_reg  = SN_CR;
        req_data = CMD_VAL;
      end
      S_CLOSE: begin
        req_wr   = WR;
        req_reg  = SN_CR;
        req_data = 16'h0010;
      end
      default: ;
    endcase
  end

  assign bus.addr    = {req_wr, req_reg};
  assign bus.wr_data = req_data;
  assign bus.done    = done_reg;
  assign bus.error   = error_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_cnt    <= 4'd0;
      retry_cnt <= 4'd0;
      tick_cnt  <= 32'd0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else if (state != S_IDLE && !bus.enable) begin
      // Abort leaves the socket as is; the host restarts from op 0.
      state     <= S_IDLE;
      op_cnt    <= 4'd0;
      retry_cnt <= 4'd0;
      tick_cnt  <= 32'd0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          op_cnt    <= 4'd0;
          retry_cnt <= 4'd0;
          tick_cnt  <= 32'd0;
          done_reg  <= 1'b0;
          error_reg <= 1'b0;
          if (bus.enable) state <= S_WRITE;
        end
        S_WRITE: begin
          if (bus.op_state) begin
            if (op_cnt == LAST_OP) begin
              op_cnt   <= 4'd0;
              tick_cnt <= 32'd0;
              state    <= S_WAIT_INIT;
            end else begin
              op_cnt <= op_cnt + 4'd1;
            end
          end
        end
        S_WAIT_INIT: begin
          if (tick_cnt >= INIT_LIMIT) begin
            tick_cnt <= 32'd0;
            state    <= S_CLOSE;
          end else if (bus.op_state && ssr == INIT_SSR) begin
            tick_cnt <= 32'd0;
            state    <= IS_UDP ? S_DONE : S_COMMAND;
          end else begin
            tick_cnt <= tick_inc;
          end
        end
        S_COMMAND: begin
          if (bus.op_state) begin
            tick_cnt <= 32'd0;
            state    <= S_WAIT_STATUS;
          end
        end
        S_WAIT_STATUS: begin
          if (tick_cnt >= STAT_LIMIT) begin
            tick_cnt <= 32'd0;
            state    <= S_CLOSE;
          end else if (bus.op_state && ssr == TARGET_SSR) begin
            tick_cnt <= 32'd0;
            state    <= S_DONE;
          end else if (IS_CLIENT && bus.op_state && ssr == 8'h00) begin
            tick_cnt <= 32'd0;
            state    <= S_CLOSE;
          end else begin
            tick_cnt <= tick_inc;
          end
        end
        S_CLOSE: begin
          if (bus.op_state) begin
            retry_cnt <= retry_inc;
            op_cnt    <= 4'd0;
            state     <= (retry_inc == MAX_RETRY) ? S_FAIL : S_WRITE;
          end
        end
        S_DONE:  done_reg  <= 1'b1;
        S_FAIL:  error_reg <= 1'b1;
        default: state     <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
